board_state_writer: RTL

Write-side sequencer for the 32-entry icon state RAM that the board display reads for the dark playable squares. It takes game-level commands (initialise board, commit a move with optional capture and promotion) and converts them into the RAM's write port: square pixel coordinates on `locX_state`/`locY_state`, the new value on `update_state`, and the write strobe on `wea_state_ram`. The write-port address is registered one cycle after the coordinates are presented, so every write is a two-cycle setup/strobe pair.

---
 rtl/board_state_if.sv | 28 ++
 rtl/board_state_writer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/board_state_if.sv
// Command and RAM write-port bundle for the board state writer.
// Names follow the icon state RAM's own port names.
interface board_state_if;
  logic       init_req;
  logic       move_req;
  logic [4:0] src_idx;
  logic [4:0] dst_idx;
  logic       cap_valid;
  logic [4:0] cap_idx;
  logic [7:0] piece;
  logic [7:0] locX_state;
  logic [7:0] locY_state;
  logic [7:0] update_state;
  logic       wea_state_ram;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output init_req, move_req, src_idx, dst_idx, cap_valid, cap_idx, piece,
    input  locX_state, locY_state, update_state, wea_state_ram, busy, done, err
  );

  modport slave (
    input  init_req, move_req, src_idx, dst_idx, cap_valid, cap_idx, piece,
    output locX_state, locY_state, update_state, wea_state_ram, busy, done, err
  );
endinterface

// File: rtl/board_state_writer.sv
// Turns init/move commands into SET/WR write pairs on the icon state RAM port.
// Coordinates and value are registered when a SET state is entered and held through WR.
module board_state_writer (
  input  logic         clk,
  input  logic         reset_n,
  board_state_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, INIT_SET, INIT_WR, DST_SET, DST_WR,
    SRC_SET, SRC_WR, CAP_SET, CAP_WR, DONE
  } state_t;

  localparam logic [7:0] PITCH      = 8'h0e;
  localparam logic [7:0] EMPTY      = 8'h00;
  localparam logic [7:0] RED_MAN    = 8'h01;
  localparam logic [7:0] BLACK_MAN  = 8'h02;
  localparam logic [7:0] RED_KING   = 8'h03;
  localparam logic [7:0] BLACK_KING = 8'h04;

  // Even rows start on the odd column, odd rows on column 0: col = 2*slot + (row even).
  function automatic logic [7:0] sq_x(input logic [4:0] idx);
    logic [7:0] col;
    col = {5'd0, idx[1:0], ~idx[2]};
    return PITCH * col;
  endfunction

  function automatic logic [7:0] sq_y(input logic [4:0] idx);
    return PITCH * {5'd0, idx[4:2]};
  endfunction

  function automatic logic [7:0] init_value(input logic [4:0] idx);
    if (idx < 5'd12)      return RED_MAN;
    else if (idx < 5'd20) return EMPTY;
    else                  return BLACK_MAN;
  endfunction

  function automatic logic [7:0] promote(input logic [7:0] p, input logic [4:0] idx);
    if (p == RED_MAN && idx[4:2] == 3'd7)        return RED_KING;
    else if (p == BLACK_MAN && idx[4:2] == 3'd0) return BLACK_KING;
    else                                         return p;
  endfunction

  state_t     state, next_state;
  logic [4:0] src_q, cap_q, init_idx;
  logic       cap_valid_q;
  logic [7:0] loc_x, loc_y, update;
  logic       err_q;

  logic       load, accept_init, accept_move, reject, move_ok;
  logic [4:0] tgt_idx;
  logic [7:0] tgt_val;

  assign move_ok = (bus.src_idx != bus.dst_idx) &&
                   !(bus.cap_valid && (bus.cap_idx == bus.src_idx ||
                                       bus.cap_idx == bus.dst_idx));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    load        = 1'b0;
    tgt_idx     = '0;
    tgt_val     = EMPTY;
    accept_init = 1'b0;
    accept_move = 1'b0;
    reject      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.init_req) begin
          accept_init = 1'b1;
          next_state  = INIT_SET;
          load        = 1'b1;
          tgt_idx     = 5'd0;
          tgt_val     = init_value(5'd0);
        end else if (bus.move_req) begin
          if (move_ok) begin
            accept_move = 1'b1;
            next_state  = DST_SET;
            load        = 1'b1;
            tgt_idx     = bus.dst_idx;
            tgt_val     = promote(bus.piece, bus.dst_idx);
          end else begin
            reject = 1'b1;
          end
        end
      end
      INIT_SET: next_state = INIT_WR;
      INIT_WR: begin
        if (init_idx == 5'd31) begin
          next_state = DONE;
        end else begin
          next_state = INIT_SET;
          load       = 1'b1;
          tgt_idx    = init_idx + 5'd1;
          tgt_val    = init_value(init_idx + 5'd1);
        end
      end
      DST_SET: next_state = DST_WR;
      DST_WR: begin
        next_state = SRC_SET;
        load       = 1'b1;
        tgt_idx    = src_q;
      end
      SRC_SET: next_state = SRC_WR;
      SRC_WR: begin
        if (cap_valid_q) begin
          next_state = CAP_SET;
          load       = 1'b1;
          tgt_idx    = cap_q;
        end else begin
          next_state = DONE;
        end
      end
      CAP_SET: next_state = CAP_WR;
      CAP_WR:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      src_q       <= '0;
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
      init_idx    <= '0;
      loc_x       <= '0;
      loc_y       <= '0;
      update      <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= reject;
      if (load) begin
        loc_x  <= sq_x(tgt_idx);
        loc_y  <= sq_y(tgt_idx);
        update <= tgt_val;
      end
      if (accept_move) begin
        src_q       <= bus.src_idx;
        cap_q       <= bus.cap_idx;
        cap_valid_q <= bus.cap_valid;
      end
      if (accept_init)          init_idx <= '0;
      else if (state == INIT_WR) init_idx <= init_idx + 5'd1;
    end
  end

  // Strobe decodes straight from the state register so reset drops it asynchronously.
  assign bus.wea_state_ram = (state == INIT_WR) || (state == DST_WR) ||
                             (state == SRC_WR)  || (state == CAP_WR);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.err           = err_q;
  assign bus.locX_state    = loc_x;
  assign bus.locY_state    = loc_y;
  assign bus.update_state  = update;

endmodule
